// File: rtl/mul_share_arb.sv
// Shared pipelined multiplier bank. Up to NCH requestors compete for one
// issue slot per cycle; the winner drives all NLANE unsigned multipliers.
// Each result returns LAT cycles later, tagged with its owning channel.
module mul_share_arb #(
   parameter int NCH   = 3,
   parameter int NLANE = 2,
   parameter int AW    = 27,
   parameter int BW    = 27,
   parameter int LAT   = 2,
   parameter int RR    = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NCH-1:0]              req,
   input  logic [NCH*NLANE*AW-1:0]     in_1,
   input  logic [NCH*NLANE*BW-1:0]     in_2,
   output logic [NCH-1:0]              gnt,
   output logic [NLANE*(AW+BW)-1:0]    out,
   output logic [NCH-1:0]              out_vld,
   output logic                        busy
);

   localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PRW = AW + BW;
   localparam int OW  = NLANE * PRW;

   // Full-width unsigned lane product; PRW bits always hold the result.
   function automatic logic [PRW-1:0] lane_mul(input logic [AW-1:0] a,
                                               input logic [BW-1:0] b);
      return PRW'(a) * PRW'(b);
   endfunction

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gidx;
   logic            gnt_any;
   logic [OW-1:0]   prod;

   logic [LAT-1:0]  vld_p;
   logic [NCH-1:0]  tag_p [LAT];
   logic [OW-1:0]   dat_p [LAT];

   // Arbiter: first asserted request, scanning from ptr (RR) or from 0.
   always_comb begin
      int c;
      c       = 0;
      gnt     = '0;
      gidx    = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         c = (RR != 0) ? ((int'(ptr) + i) % NCH) : i;
         if (!gnt_any && !reset && req[c]) begin
            gnt_any = 1'b1;
            gnt[c]  = 1'b1;
            gidx    = PW'(c);
         end
      end
   end

   // Round-robin pointer moves just past the channel that won.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (gnt_any)
         ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
   end

   // Operand select for the granted channel and the lane multipliers.
   always_comb begin
      prod = '0;
      for (int k = 0; k < NLANE; k++)
         prod[k*PRW +: PRW] = lane_mul(in_1[(int'(gidx)*NLANE + k)*AW +: AW],
                                       in_2[(int'(gidx)*NLANE + k)*BW +: BW]);
   end

   // Pipeline control: valid and owner tag; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p <= '0;
         for (int s = 0; s < LAT; s++)
            tag_p[s] <= '0;
      end else begin
         vld_p[0] <= gnt_any;
         if (gnt_any)
            tag_p[0] <= gnt;
         for (int s = 1; s < LAT; s++) begin
            vld_p[s] <= vld_p[s-1];
            if (vld_p[s-1])
               tag_p[s] <= tag_p[s-1];
         end
      end
   end

   // Pipeline data: stages load only on valid, so the last stage holds the
   // most recent result; that last stage is the output register.
   always_ff @(posedge clk) begin
      if (gnt_any)
         dat_p[0] <= prod;
      for (int s = 1; s < LAT; s++)
         if (vld_p[s-1])
            dat_p[s] <= dat_p[s-1];
      if (reset)
         dat_p[LAT-1] <= '0;
   end

   // Outputs from the final stage.
   always_comb begin
      out     = dat_p[LAT-1];
      out_vld = vld_p[LAT-1] ? tag_p[LAT-1] : '0;
      busy    = |vld_p;
   end

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: a fixed-priority LAT=2 instance and a
// round-robin LAT=1 instance driven by directed and random requestors,
// checked against a queue-based reference of grants and products.
module tb_mul_share_arb;

   localparam int NCH   = 3;
   localparam int NLANE = 2;
   localparam int AW    = 27;
   localparam int BW    = 27;
   localparam int PRW   = AW + BW;
   localparam int OW    = NLANE * PRW;
   localparam int IW1   = NCH * NLANE * AW;
   localparam int IW2   = NCH * NLANE * BW;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic reset;
   logic [NCH-1:0] req_s  [2];
   logic [IW1-1:0] in1_s  [2];
   logic [IW2-1:0] in2_s  [2];
   logic [NCH-1:0] gnt_s  [2];
   logic [OW-1:0]  out_s  [2];
   logic [NCH-1:0] vld_s  [2];
   logic           busy_s [2];

   mul_share_arb #(.NCH(NCH), .NLANE(NLANE), .AW(AW), .BW(BW), .LAT(LAT_A), .RR(0)) u_fp (
      .clk(clk), .reset(reset), .req(req_s[0]), .in_1(in1_s[0]), .in_2(in2_s[0]),
      .gnt(gnt_s[0]), .out(out_s[0]), .out_vld(vld_s[0]), .busy(busy_s[0]));

   mul_share_arb #(.NCH(NCH), .NLANE(NLANE), .AW(AW), .BW(BW), .LAT(LAT_B), .RR(1)) u_rr (
      .clk(clk), .reset(reset), .req(req_s[1]), .in_1(in1_s[1]), .in_2(in2_s[1]),
      .gnt(gnt_s[1]), .out(out_s[1]), .out_vld(vld_s[1]), .busy(busy_s[1]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int             d;
      int             g;
      int             due;
      logic [NCH-1:0] tag;
      logic [OW-1:0]  data;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            pend [2][NCH];
   int            ptr_m [2];
   logic [OW-1:0] last_out [2];

   task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp_v);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT_A : LAT_B;
   endfunction

   function automatic logic [AW-1:0] rnd_op();
      logic [AW-1:0] v;
      case ($urandom_range(0, 3))
         0:       v = '1;
         1:       v = AW'($urandom_range(0, 15));
         default: v = AW'($urandom);
      endcase
      return v;
   endfunction

   task automatic new_req(input int d, input int c, input logic [AW-1:0] a0, input logic [BW-1:0] b0,
                          input logic [AW-1:0] a1, input logic [BW-1:0] b1);
      in1_s[d][(c*NLANE + 0)*AW +: AW] = a0;
      in2_s[d][(c*NLANE + 0)*BW +: BW] = b0;
      in1_s[d][(c*NLANE + 1)*AW +: AW] = a1;
      in2_s[d][(c*NLANE + 1)*BW +: BW] = b1;
      pend[d][c] = 1'b1;
   endtask

   task automatic rnd_req(input int d, input int c);
      new_req(d, c, rnd_op(), rnd_op(), rnd_op(), rnd_op());
   endtask

   // Reference grant: first pending channel in search order; record result.
   task automatic grant_check(input int d);
      int win;
      int c;
      logic [NCH-1:0] e;
      logic [OW-1:0] data;
      longint unsigned a, b, p;
      exp_t it;
      win = -1;
      e = '0;
      data = '0;
      if (!reset)
         for (int i = 0; i < NCH; i++) begin
            c = (d == 1) ? (ptr_m[d] + i) % NCH : i;
            if (win < 0 && pend[d][c]) win = c;
         end
      if (win >= 0) e[win] = 1'b1;
      check((d == 0) ? "gnt_fp" : "gnt_rr", OW'(gnt_s[d]), OW'(e));
      if (win >= 0) begin
         for (int k = 0; k < NLANE; k++) begin
            a = 64'(in1_s[d][(win*NLANE + k)*AW +: AW]);
            b = 64'(in2_s[d][(win*NLANE + k)*BW +: BW]);
            p = a * b;
            data[k*PRW +: PRW] = p[PRW-1:0];
         end
         it.d = d; it.g = cyc; it.due = cyc + lat_of(d); it.tag = e; it.data = data;
         sb.push_back(it);
         pend[d][win] = 1'b0;
         ptr_m[d] = (win + 1) % NCH;
      end
      if (reset) ptr_m[d] = 0;
   endtask

   task automatic step(input bit rst_v);
      reset = rst_v;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++)
            req_s[d][c] = pend[d][c];
      @(negedge clk);
      for (int d = 0; d < 2; d++) grant_check(d);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares out/out_vld/busy against the scoreboard each cycle.
   initial begin
      int hit;
      bit bsy;
      logic [NCH-1:0] ev;
      logic [OW-1:0] eo;
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            hit = -1;
            bsy = 1'b0;
            ev = '0;
            eo = last_out[d];
            foreach (sb[i]) begin
               if (sb[i].d == d && sb[i].g < cyc) bsy = 1'b1;
               if (sb[i].d == d && sb[i].due == cyc) hit = i;
            end
            if (hit >= 0) begin
               ev = sb[hit].tag;
               eo = sb[hit].data;
               last_out[d] = eo;
               sb.delete(hit);
            end
            check((d == 0) ? "vld_fp" : "vld_rr", OW'(vld_s[d]), OW'(ev));
            check((d == 0) ? "out_fp" : "out_rr", out_s[d], eo);
            check((d == 0) ? "busy_fp" : "busy_rr", OW'(busy_s[d]), OW'(bsy));
            if (reset) begin
               for (int i = sb.size() - 1; i >= 0; i--)
                  if (sb[i].d == d) sb.delete(i);
               last_out[d] = '0;
            end
         end
      end
   end

   // Stimulus
   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_s[d] = '0;
         in1_s[d] = '0;
         in2_s[d] = '0;
         ptr_m[d] = 0;
         last_out[d] = '0;
         for (int c = 0; c < NCH; c++) pend[d][c] = 1'b0;
      end
      repeat (3) step(1'b1);

      // Two channels at once: products 15,14 then 16,9.
      for (int d = 0; d < 2; d++) begin
         new_req(d, 0, 3, 5, 7, 2);
         new_req(d, 1, 4, 4, 1, 9);
      end
      repeat (4) step(1'b0);

      // Single grant then idle: out must hold 42.
      for (int d = 0; d < 2; d++) new_req(d, 2, 6, 7, 0, 0);
      repeat (6) step(1'b0);

      // All channels requesting continuously.
      for (int n = 0; n < 6; n++) begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++)
               if (!pend[d][c]) rnd_req(d, c);
         step(1'b0);
      end
      repeat (4) step(1'b0);

      // Reset while operations are in flight, request held through reset.
      for (int d = 0; d < 2; d++) begin
         new_req(d, 0, 11, 13, 2, 3);
         new_req(d, 1, 17, 19, 5, 7);
      end
      step(1'b0);
      step(1'b1);
      repeat (4) step(1'b0);

      // All-ones operands on every lane.
      for (int d = 0; d < 2; d++) new_req(d, 0, '1, '1, '1, '1);
      repeat (4) step(1'b0);

      // Randomised traffic with withdrawals, idle windows and resets.
      for (int n = 0; n < 800; n++) begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               if (pend[d][c]) begin
                  if ($urandom_range(0, 11) == 0) pend[d][c] = 1'b0;
               end else if ((n % 60) < 50 && $urandom_range(0, 1) == 1) begin
                  rnd_req(d, c);
               end
            end
         step($urandom_range(0, 39) == 0);
      end

      repeat (10) step(1'b0);
      check("sb_drained", OW'(sb.size()), OW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
